// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-indexed data memory with combinational read.
// Optional macro LSU_MISALIGN_CHECK_EN: report misaligned accesses instead of forcing low address bits.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_q_i
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [1:0]    off_q, off_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          we_q, we_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]    resp_err_q, resp_err_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;

  logic          accept;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic [DW-1:0] eff_addr;
  logic [1:0]    req_err;

  // Extract and extend the addressed lane of a little-endian word.
  function automatic logic [DW-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [DW-1:0] w);
    logic [DW-1:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_ext = {16'h0, sh[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Replace the addressed byte/half lane of the old word with the store data.
  function automatic logic [DW-1:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [DW-1:0] old, input logic [DW-1:0] wd);
    logic [DW-1:0] mask;
    case (f3)
      3'b000:  mask = 32'h0000_00FF << {off, 3'b000};
      3'b001:  mask = 32'h0000_FFFF << {off, 3'b000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    merge = (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  // Request classification on the incoming (not yet latched) request.
  always_comb begin
    illegal    = req_we_i ? (req_funct3_i > 3'b010)
                          : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
    misaligned = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                 (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    eff_addr   = req_addr_i;
`ifndef LSU_MISALIGN_CHECK_EN
    if (req_funct3_i[1:0] == 2'b10) begin
      eff_addr = req_addr_i & ~32'h3;
    end else if (req_funct3_i[1:0] == 2'b01) begin
      eff_addr = req_addr_i & ~32'h1;
    end
`endif
    out_of_range = ({2'b00, eff_addr[31:2]} >= DW'(MEM_WORDS));
    if (illegal) begin
      req_err = ERR_FUNCT3;
`ifdef LSU_MISALIGN_CHECK_EN
    end else if (misaligned) begin
      req_err = ERR_MISALIGN;
`endif
    end else if (out_of_range) begin
      req_err = ERR_RANGE;
    end else begin
      req_err = ERR_OK;
    end
  end

  assign accept = req_valid_i && req_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    resp_rdata_d = '0;
    resp_err_d   = ERR_OK;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          off_d      = eff_addr[1:0];
          wdata_d    = req_wdata_i;
          funct3_d   = req_funct3_i;
          we_d       = req_we_i;
          mem_addr_d = {2'b00, eff_addr[31:2]};
          if (req_err != ERR_OK) begin
            state_d    = S_ERR;
            resp_err_d = req_err;
          end else if (req_we_i && req_funct3_i == 3'b010) begin
            state_d    = S_WR;
            mem_data_d = req_wdata_i;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d    = S_WR;
          mem_data_d = merge(funct3_q, off_q, mem_q_i, wdata_q);
        end else begin
          state_d      = S_RESP;
          resp_rdata_d = load_ext(funct3_q, off_q, mem_q_i);
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP) || (state_d == S_ERR);
    mem_we_d     = (state_d == S_WR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q        <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_we_o     = mem_we_q;

endmodule
